// File: rtl/step_key_controller.sv
// step_key_controller
// Turns the two raw push-keys into single-cycle step requests for the LED bar counter.
// The keys are synchronised and debounced. Simultaneous presses are resolved by a lock
// state. A press gives one step, then auto-repeat follows while the key is held.
// Ports:
//   clk       system clock
//   reset     synchronous, active-low reset
//   key_up_n  raw up key, active-low, asynchronous
//   key_dn_n  raw down key, active-low, asynchronous
//   count_i   current counter value, used for the saturation check
//   inc_o     one-cycle increment request
//   dec_o     one-cycle decrement request
//   state_o   FSM state: 0 idle, 1 hold, 2 repeat, 3 lock
module step_key_controller #(
    parameter int unsigned CNT_W           = 3,
    parameter int unsigned COUNT_MAX       = 7,
    parameter bit          SATURATE        = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_up_n,
    input  logic             key_dn_n,
    input  logic [CNT_W-1:0] count_i,
    output logic             inc_o,
    output logic             dec_o,
    output logic [1:0]       state_o
);

    localparam int unsigned TimerMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW = $clog2(TimerMax + 1);
    // The debounce counter never needs to hold more than DEBOUNCE_CYCLES-1.
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [TW-1:0] HoldLoad   = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] RepeatLoad = TW'(REPEAT_CYCLES);
    localparam logic [DW-1:0] DebLast    = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHold   = 2'd1,
        StRepeat = 2'd2,
        StLock   = 2'd3
    } state_e;

    // ---------------------------------------------------------------------------------------
    // Synchroniser and debouncer. Index 0 is the up key, index 1 the down key; all levels
    // are kept active-low.
    // ---------------------------------------------------------------------------------------
    logic [1:0]    raw_n;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    deb_n_q, deb_n_d;
    logic [DW-1:0] deb_cnt_q [2];
    logic [DW-1:0] deb_cnt_d [2];

    assign raw_n = {key_dn_n, key_up_n};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_n_d[i]   = deb_n_q[i];
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_n_q[i]) begin
                // Accept the new level on the DEBOUNCE_CYCLES-th consecutive mismatch.
                if (deb_cnt_q[i] == DebLast) begin
                    deb_n_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            deb_n_q      <= '1;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
        end else begin
            sync1_q      <= raw_n;
            sync2_q      <= sync1_q;
            deb_n_q      <= deb_n_d;
            deb_cnt_q[0] <= deb_cnt_d[0];
            deb_cnt_q[1] <= deb_cnt_d[1];
        end
    end

    // ---------------------------------------------------------------------------------------
    // Step FSM
    // ---------------------------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          dir_up_q, dir_up_d;
    logic          inc_q, inc_d;
    logic          dec_q, dec_d;
    logic          up, dn, active, other;
    logic          req_inc, req_dec;
    logic          at_max, at_zero;

    assign up      = ~deb_n_q[0];
    assign dn      = ~deb_n_q[1];
    assign active  = dir_up_q ? up : dn;
    assign other   = dir_up_q ? dn : up;
    assign at_max  = (count_i == CNT_W'(COUNT_MAX));
    assign at_zero = (count_i == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            dir_up_q <= 1'b0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            dir_up_q <= dir_up_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        dir_up_d = dir_up_q;
        req_inc  = 1'b0;
        req_dec  = 1'b0;
        case (state_q)
            StIdle: begin
                if (up && dn) begin
                    state_d = StLock;
                end else if (up) begin
                    req_inc  = 1'b1;
                    dir_up_d = 1'b1;
                    state_d  = StHold;
                    timer_d  = HoldLoad;
                end else if (dn) begin
                    req_dec  = 1'b1;
                    dir_up_d = 1'b0;
                    state_d  = StHold;
                    timer_d  = HoldLoad;
                end
            end
            StHold, StRepeat: begin
                // Release is tested first so it beats a coincident timer expiry.
                if (!active) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else if (other) begin
                    state_d = StLock;
                    timer_d = '0;
                end else if (timer_q == TW'(1)) begin
                    req_inc = dir_up_q;
                    req_dec = ~dir_up_q;
                    state_d = StRepeat;
                    timer_d = RepeatLoad;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            StLock: begin
                if (!up && !dn) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
        // Saturation only masks the pulse; the FSM and timer advance regardless.
        inc_d = req_inc & ~(SATURATE & at_max);
        dec_d = req_dec & ~(SATURATE & at_zero);
    end

    always_comb begin
        state_o = state_q;
        inc_o   = inc_q;
        dec_o   = dec_q;
    end

endmodule
